// File: rtl/bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_timer_ctrl
//
// Parametrised BCD timekeeping core: stopwatch (count up) or countdown
// (count down) over NUM_FIELDS two-digit BCD fields. Field 0 is seconds,
// fields 1..NUM_FIELDS-2 run 0-59, and the top field runs 0..TOP_MAX.
// Fields can be set one at a time in adjust mode, using a cursor.
// Consumes single-cycle strobes only; contains no dividers.
//
// Parameters
//   NUM_FIELDS  number of two-digit fields (2..4)
//   TOP_MAX     maximum value of the top field (1..99)
//   WRAP_UP     1: up-count overflow wraps to zero
//               0: up-count saturates at all-max and stops
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   1 Hz count strobe
//   mode       in   0 = count up, 1 = count down
//   run_tgl    in   run/stop toggle pulse
//   adj        in   adjust-mode level
//   cur_next   in   advance the adjust cursor
//   inc, dec   in   step the field under the cursor
//   alarm_ack  in   clear a pending alarm
//   digits     out  BCD fields; field f occupies [8f+7:8f]
//   cursor     out  field selected for adjust
//   running    out  counting active
//   alarm      out  countdown reached zero, not yet acknowledged
//   zero       out  combinational: all digits are zero
//
// Build option
//   BCD_TIMER_ALARM_EN  when defined, countdown expiry enters an ALARM state
//                       that holds until alarm_ack or adj. When undefined,
//                       expiry returns to STOP, alarm is tied 0 and
//                       alarm_ack is ignored.
// ---------------------------------------------------------------------------
module bcd_timer_ctrl #(
   parameter int NUM_FIELDS = 2,
   parameter int TOP_MAX    = 59,
   parameter int WRAP_UP    = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  tick,
   input  logic                                  mode,
   input  logic                                  run_tgl,
   input  logic                                  adj,
   input  logic                                  cur_next,
   input  logic                                  inc,
   input  logic                                  dec,
   input  logic                                  alarm_ack,
   output logic [8*NUM_FIELDS-1:0]               digits,
   output logic [((NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1)-1:0] cursor,
   output logic                                  running,
   output logic                                  alarm,
   output logic                                  zero
);

   localparam int unsigned NF = NUM_FIELDS;
   localparam int          CW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int          DW = 8 * NUM_FIELDS;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_ADJ  = 2'd2
`ifdef BCD_TIMER_ALARM_EN
      ,
      ST_ALARM = 2'd3
`endif
   } state_t;

`ifdef BCD_TIMER_ALARM_EN
   localparam state_t ST_EXPIRE = ST_ALARM;
`else
   localparam state_t ST_EXPIRE = ST_STOP;
`endif

   // Binary value (0..99) to two BCD digits.
   function automatic logic [7:0] to_bcd(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Maximum BCD value of field f.
   function automatic logic [7:0] fmax(input int unsigned f);
      return (f == NF - 1) ? to_bcd(unsigned'(TOP_MAX)) : 8'h59;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
      if (v == mx)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
      if (v == 8'h00)
         return mx;
      else if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   state_t          state, state_nx;
   logic [DW-1:0]   digits_nx;
   logic [CW-1:0]   cursor_nx;
   logic [DW-1:0]   up_val, dn_val;
   logic            up_ovf, borrow;
   logic            dn_zero;

   assign zero = (digits == '0);

`ifndef BCD_TIMER_ALARM_EN
   logic unused_alarm_ack;
   assign unused_alarm_ack = alarm_ack;
`endif

   // Full-width successor/predecessor with ripple across fields. A field only
   // steps when every lower field rolled over; up_ovf means all were at max.
   always_comb begin
      up_val = digits;
      dn_val = digits;
      up_ovf = 1'b1;
      borrow = 1'b1;
      for (int unsigned f = 0; f < NF; f++) begin
         if (up_ovf) begin
            up_val[8*f +: 8] = bcd_inc(digits[8*f +: 8], fmax(f));
            up_ovf = (digits[8*f +: 8] == fmax(f));
         end
         if (borrow) begin
            dn_val[8*f +: 8] = bcd_dec(digits[8*f +: 8], fmax(f));
            borrow = (digits[8*f +: 8] == 8'h00);
         end
      end
      dn_zero = (dn_val == '0);
   end

   always_comb begin
      state_nx  = state;
      digits_nx = digits;
      cursor_nx = cursor;
      unique case (state)
         ST_STOP: begin
            if (adj)
               state_nx = ST_ADJ;
            else if (run_tgl && !(mode && zero))
               state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (adj)
               state_nx = ST_ADJ;
            else if (run_tgl)
               state_nx = ST_STOP;
            else if (tick) begin
               if (!mode) begin
                  if (up_ovf && (WRAP_UP == 0))
                     state_nx = ST_STOP;
                  else
                     digits_nx = up_val;
               end else begin
                  // A tick at zero (mode flipped mid-run) expires without
                  // touching the digits.
                  if (zero)
                     state_nx = ST_EXPIRE;
                  else begin
                     digits_nx = dn_val;
                     if (dn_zero)
                        state_nx = ST_EXPIRE;
                  end
               end
            end
         end
         ST_ADJ: begin
            if (!adj)
               state_nx = ST_STOP;
            else begin
               for (int unsigned f = 0; f < NF; f++) begin
                  if (CW'(f) == cursor) begin
                     if (inc && !dec)
                        digits_nx[8*f +: 8] = bcd_inc(digits[8*f +: 8], fmax(f));
                     else if (dec && !inc)
                        digits_nx[8*f +: 8] = bcd_dec(digits[8*f +: 8], fmax(f));
                  end
               end
               if (cur_next)
                  cursor_nx = (cursor == CW'(NF - 1)) ? '0 : cursor + 1'b1;
            end
         end
`ifdef BCD_TIMER_ALARM_EN
         ST_ALARM: begin
            if (adj)
               state_nx = ST_ADJ;
            else if (alarm_ack)
               state_nx = ST_STOP;
         end
`endif
         default: state_nx = ST_STOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_STOP;
         digits  <= '0;
         cursor  <= '0;
         running <= 1'b0;
      end else begin
         state   <= state_nx;
         digits  <= digits_nx;
         cursor  <= cursor_nx;
         running <= (state_nx == ST_RUN);
      end
   end

`ifdef BCD_TIMER_ALARM_EN
   always_ff @(posedge clk) begin
      if (rst)
         alarm <= 1'b0;
      else
         alarm <= (state_nx == ST_ALARM);
   end
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_timer_ctrl
//
// Two instances share one stimulus stream:
//   dut_a  NUM_FIELDS=3, TOP_MAX=23, WRAP_UP=1  (hh:mm:ss, wraps)
//   dut_b  NUM_FIELDS=2, TOP_MAX=59, WRAP_UP=0  (mm:ss, saturates)
// The reference model holds each timer as a single integer count of seconds
// and derives fields with div/mod, so it shares no structure with the RTL.
// ---------------------------------------------------------------------------
module tb_bcd_timer_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, tick, mode, run_tgl, adj, cur_next, inc, dec, alarm_ack;
   logic [23:0] dig_a;
   logic [1:0]  cur_a;
   logic        run_a, alm_a, zero_a;
   logic [15:0] dig_b;
   logic        cur_b;
   logic        run_b, alm_b, zero_b;

   bcd_timer_ctrl #(.NUM_FIELDS(3), .TOP_MAX(23), .WRAP_UP(1)) dut_a (
      .clk(clk), .rst(rst), .tick(tick), .mode(mode), .run_tgl(run_tgl),
      .adj(adj), .cur_next(cur_next), .inc(inc), .dec(dec),
      .alarm_ack(alarm_ack), .digits(dig_a), .cursor(cur_a),
      .running(run_a), .alarm(alm_a), .zero(zero_a));

   bcd_timer_ctrl #(.NUM_FIELDS(2), .TOP_MAX(59), .WRAP_UP(0)) dut_b (
      .clk(clk), .rst(rst), .tick(tick), .mode(mode), .run_tgl(run_tgl),
      .adj(adj), .cur_next(cur_next), .inc(inc), .dec(dec),
      .alarm_ack(alarm_ack), .digits(dig_b), .cursor(cur_b),
      .running(run_b), .alarm(alm_b), .zero(zero_b));

`ifdef BCD_TIMER_ALARM_EN
   localparam bit ALM_EN = 1'b1;
`else
   localparam bit ALM_EN = 1'b0;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   localparam int M_STOP = 0, M_RUN = 1, M_ADJ = 2, M_ALARM = 3;

   typedef struct {
      int val;   // total count in seconds-equivalent units
      int cur;
      int st;
      bit alm;
   } mdl_t;

   mdl_t ma, mb;

   function automatic int pw60(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r *= 60;
      return r;
   endfunction

   function automatic int fget(input int v, input int f, input int nf);
      return (f < nf - 1) ? (v / pw60(f)) % 60 : v / pw60(nf - 1);
   endfunction

   function automatic int to_digits(input int v, input int nf);
      int r = 0;
      for (int f = 0; f < nf; f++) begin
         int fv = fget(v, f, nf);
         r += ((fv / 10) * 16 + fv % 10) << (8 * f);
      end
      return r;
   endfunction

   function automatic mdl_t mstep(input mdl_t m0, input int nf, input int top, input bit wrap);
      mdl_t m = m0;
      int total = pw60(nf - 1) * (top + 1);
      if (rst) begin
         m.val = 0; m.cur = 0; m.st = M_STOP; m.alm = 1'b0;
         return m;
      end
      case (m.st)
         M_STOP: begin
            if (adj) m.st = M_ADJ;
            else if (run_tgl && !(mode && m.val == 0)) m.st = M_RUN;
         end
         M_RUN: begin
            if (adj) m.st = M_ADJ;
            else if (run_tgl) m.st = M_STOP;
            else if (tick) begin
               if (!mode) begin
                  if (m.val == total - 1) begin
                     if (wrap) m.val = 0;
                     else m.st = M_STOP;
                  end else m.val++;
               end else begin
                  if (m.val > 0) m.val--;
                  if (m.val == 0) begin
                     m.st  = ALM_EN ? M_ALARM : M_STOP;
                     m.alm = ALM_EN;
                  end
               end
            end
         end
         M_ADJ: begin
            if (!adj) m.st = M_STOP;
            else begin
               if (inc != dec) begin
                  int fv  = fget(m.val, m.cur, nf);
                  int fmx = (m.cur == nf - 1) ? top : 59;
                  int nv  = inc ? ((fv == fmx) ? 0 : fv + 1) : ((fv == 0) ? fmx : fv - 1);
                  m.val += (nv - fv) * pw60(m.cur);
               end
               if (cur_next) m.cur = (m.cur + 1) % nf;
            end
         end
         default: begin
            if (adj) begin m.st = M_ADJ; m.alm = 1'b0; end
            else if (alarm_ack) begin m.st = M_STOP; m.alm = 1'b0; end
         end
      endcase
      return m;
   endfunction

   // One clock: sample inputs at the edge, advance the model, compare #1 later.
   task automatic step();
      @(posedge clk);
      ma = mstep(ma, 3, 23, 1'b1);
      mb = mstep(mb, 2, 59, 1'b0);
      #1;
      check("a_digits",  32'(dig_a),  32'(to_digits(ma.val, 3)));
      check("a_cursor",  32'(cur_a),  32'(ma.cur));
      check("a_running", 32'(run_a),  32'(ma.st == M_RUN));
      check("a_alarm",   32'(alm_a),  32'(ma.alm));
      check("a_zero",    32'(zero_a), 32'(ma.val == 0));
      check("b_digits",  32'(dig_b),  32'(to_digits(mb.val, 2)));
      check("b_cursor",  32'(cur_b),  32'(mb.cur));
      check("b_running", 32'(run_b),  32'(mb.st == M_RUN));
      check("b_alarm",   32'(alm_b),  32'(mb.alm));
      check("b_zero",    32'(zero_b), 32'(mb.val == 0));
      rst = 0; tick = 0; run_tgl = 0; cur_next = 0; inc = 0; dec = 0; alarm_ack = 0;
   endtask

   initial begin
      ma = '{0, 0, M_STOP, 1'b0};
      mb = '{0, 0, M_STOP, 1'b0};
      rst = 1; tick = 0; mode = 0; run_tgl = 0; adj = 0;
      cur_next = 0; inc = 0; dec = 0; alarm_ack = 0;
      step();
      check("rst_dig_a", 32'(dig_a), 32'h0);
      check("rst_cur_a", 32'(cur_a), 32'h0);
      check("rst_run_a", 32'(run_a), 32'h0);
      check("rst_alm_b", 32'(alm_b), 32'h0);

      // Preload via adjust: a -> 23:59:59, b -> 59:58
      adj = 1; step();
      dec = 1; step();
      cur_next = 1; step();
      dec = 1; step();
      check("adj_cur1_b", 32'(cur_b), 32'h1);
      cur_next = 1; step();
      dec = 1; step();
      check("pre_a", 32'(dig_a), 32'h235959);
      check("pre_b", 32'(dig_b), 32'h5958);
      inc = 1; dec = 1; step();
      check("incdec_a", 32'(dig_a), 32'h235959);
      tick = 1; step();
      check("adj_tick_b", 32'(dig_b), 32'h5958);
      adj = 0; step();
      mode = 0; run_tgl = 1; step();

      tick = 1; step();
      check("wrap_a", 32'(dig_a), 32'h000000);
      check("wrap_run_a", 32'(run_a), 32'h1);
      check("up_b", 32'(dig_b), 32'h5959);
      tick = 1; step();
      check("sat_b", 32'(dig_b), 32'h5959);
      check("sat_run_b", 32'(run_b), 32'h0);
      check("after_wrap_a", 32'(dig_a), 32'h000001);
      // a: RUN + run_tgl + tick -> STOP, no count; b: STOP + run_tgl + tick -> RUN, no count
      run_tgl = 1; tick = 1; step();
      check("rt_tick_a", 32'(dig_a), 32'h000001);
      check("rt_tick_run_a", 32'(run_a), 32'h0);
      check("rt_tick_b", 32'(dig_b), 32'h5959);
      check("rt_tick_run_b", 32'(run_b), 32'h1);

      // Countdown from 00:02
      rst = 1; step();
      adj = 1; step();
      inc = 1; step();
      inc = 1; step();
      adj = 0; step();
      mode = 1; run_tgl = 1; step();
      tick = 1; step();
      check("dn1_b", 32'(dig_b), 32'h0001);
      tick = 1; step();
      check("dn0_b", 32'(dig_b), 32'h0000);
      check("dn0_alm_b", 32'(alm_b), 32'(ALM_EN));
      check("dn0_run_b", 32'(run_b), 32'h0);
      tick = 1; step();
      check("dn_hold_a", 32'(dig_a), 32'h000000);
      alarm_ack = 1; step();
      check("ack_alm_b", 32'(alm_b), 32'h0);
      run_tgl = 1; step();
      check("zero_rtgl_b", 32'(run_b), 32'h0);

      // Reset coinciding with tick and inc while running
      mode = 0; run_tgl = 1; step();
      tick = 1; step();
      rst = 1; tick = 1; inc = 1; step();
      check("srst_dig_a", 32'(dig_a), 32'h0);
      check("srst_run_a", 32'(run_a), 32'h0);
      check("srst_dig_b", 32'(dig_b), 32'h0);

      // Randomised phase against the model
      for (int n = 0; n < 4000; n++) begin
         rst       = ($urandom_range(0, 999) == 0);
         tick      = ($urandom_range(0, 2) == 0);
         run_tgl   = ($urandom_range(0, 11) == 0);
         cur_next  = ($urandom_range(0, 5) == 0);
         inc       = ($urandom_range(0, 4) == 0);
         dec       = ($urandom_range(0, 3) == 0);
         alarm_ack = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) adj = ~adj;
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
